// File: rtl/kbd_decoder.sv
// PS/2 Set-2 scancode decoder: tracks make/break/extended prefixes and Shift/CapsLock,
// translates make codes to ASCII and queues them in a small FIFO with a valid/ready handshake.
module kbd_decoder #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] key_data,
  input  logic       key_valid,
  output logic [7:0] ascii_out,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       key_down,
  output logic [7:0] last_code,
  output logic       caps_on,
  output logic       overflow
);

  localparam logic [7:0] CODE_BREAK  = 8'hF0;
  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_e;

  typedef struct packed {
    logic       hit;
    logic       letter;
    logic [7:0] ch;
  } map_t;

  function automatic map_t map_code(input logic [7:0] code);
    map_t m;
    m.hit    = 1'b1;
    m.letter = 1'b0;
    m.ch     = 8'h00;
    case (code)
      8'h1C: m.ch = "a";  8'h32: m.ch = "b";  8'h21: m.ch = "c";  8'h23: m.ch = "d";
      8'h24: m.ch = "e";  8'h2B: m.ch = "f";  8'h34: m.ch = "g";  8'h33: m.ch = "h";
      8'h43: m.ch = "i";  8'h3B: m.ch = "j";  8'h42: m.ch = "k";  8'h4B: m.ch = "l";
      8'h3A: m.ch = "m";  8'h31: m.ch = "n";  8'h44: m.ch = "o";  8'h4D: m.ch = "p";
      8'h15: m.ch = "q";  8'h2D: m.ch = "r";  8'h1B: m.ch = "s";  8'h2C: m.ch = "t";
      8'h3C: m.ch = "u";  8'h2A: m.ch = "v";  8'h1D: m.ch = "w";  8'h22: m.ch = "x";
      8'h35: m.ch = "y";  8'h1A: m.ch = "z";
      8'h45: m.ch = "0";  8'h16: m.ch = "1";  8'h1E: m.ch = "2";  8'h26: m.ch = "3";
      8'h25: m.ch = "4";  8'h2E: m.ch = "5";  8'h36: m.ch = "6";  8'h3D: m.ch = "7";
      8'h3E: m.ch = "8";  8'h46: m.ch = "9";
      8'h29: m.ch = 8'h20;
      8'h5A: m.ch = 8'h0D;
      8'h66: m.ch = 8'h08;
      default: m.hit = 1'b0;
    endcase
    m.letter = m.hit && (m.ch >= "a") && (m.ch <= "z");
    return m;
  endfunction

  state_e state_q, state_d;
  logic   lshift_q, lshift_d, rshift_q, rshift_d;
  logic   caps_q, caps_d, caps_held_q, caps_held_d;
  logic   key_down_q, key_down_d, overflow_q, overflow_d;
  logic [7:0] last_code_q, last_code_d;

  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic make_evt, break_evt, is_mod, upper, push_req, push, pop, full;
  logic [7:0] char;
  map_t   map;

  // State register.
  // NOTE: sequential state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the FSM only advances on a valid byte.
  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (key_valid) begin
      case (state_q)
        IDLE: begin
          if (key_data == CODE_BREAK)     state_d = BREAK;
          else if (key_data == CODE_EXT)  state_d = EXT;
        end
        BREAK:     state_d = IDLE;
        EXT:       state_d = (key_data == CODE_BREAK) ? EXT_BREAK : IDLE;
        EXT_BREAK: state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Output decode: extended makes and extended breaks fall through as no event.
  always_comb begin
    make_evt  = 1'b0;
    break_evt = 1'b0;
    if (key_valid) begin
      make_evt  = (state_q == IDLE) && (key_data != CODE_BREAK) && (key_data != CODE_EXT);
      break_evt = (state_q == BREAK);
    end
  end

  assign is_mod   = (key_data == CODE_LSHIFT) || (key_data == CODE_RSHIFT) || (key_data == CODE_CAPS);
  assign map      = map_code(key_data);
  assign upper    = (lshift_q | rshift_q) ^ caps_q;
  assign char     = (map.letter && upper) ? (map.ch - 8'h20) : map.ch;
  assign push_req = make_evt && !is_mod && map.hit;

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    caps_d      = caps_q;
    caps_held_d = caps_held_q;
    key_down_d  = key_down_q;
    last_code_d = last_code_q;
    if (make_evt) begin
      case (key_data)
        CODE_LSHIFT: lshift_d = 1'b1;
        CODE_RSHIFT: rshift_d = 1'b1;
        CODE_CAPS: begin
          caps_d      = caps_q ^ ~caps_held_q;
          caps_held_d = 1'b1;
        end
        default: begin
          last_code_d = key_data;
          key_down_d  = 1'b1;
        end
      endcase
    end else if (break_evt) begin
      case (key_data)
        CODE_LSHIFT: lshift_d    = 1'b0;
        CODE_RSHIFT: rshift_d    = 1'b0;
        CODE_CAPS:   caps_held_d = 1'b0;
        default:     if (key_data == last_code_q) key_down_d = 1'b0;
      endcase
    end
  end

  // FIFO control; a full FIFO still accepts a push when the head leaves on the same edge.
  assign full        = (count_q == FULL_CNT);
  assign ascii_valid = (count_q != '0);
  assign pop         = ascii_valid && ascii_ready;
  assign push        = push_req && (!full || pop);

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q | (push_req && full && !pop);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      caps_q      <= 1'b0;
      caps_held_q <= 1'b0;
      key_down_q  <= 1'b0;
      last_code_q <= 8'h00;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      caps_q      <= caps_d;
      caps_held_q <= caps_held_d;
      key_down_q  <= key_down_d;
      last_code_q <= last_code_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; ascii_out is gated by ascii_valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= char;
  end

  assign ascii_out = ascii_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign key_down  = key_down_q;
  assign last_code = last_code_q;
  assign caps_on   = caps_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_kbd_decoder.sv
// Self-checking bench for kbd_decoder: directed scenarios plus randomized scancode streams
// compared against a behavioural keyboard model.
module tb_kbd_decoder;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] key_data = 8'h00;
  logic       key_valid = 1'b0;
  logic [7:0] ascii_out;
  logic       ascii_valid;
  logic       ascii_ready = 1'b1;
  logic       key_down;
  logic [7:0] last_code;
  logic       caps_on;
  logic       overflow;

  int n_pass = 0;
  int n_total = 0;

  kbd_decoder #(.DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .reset(reset), .key_data(key_data), .key_valid(key_valid),
    .ascii_out(ascii_out), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .key_down(key_down), .last_code(last_code), .caps_on(caps_on), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Characters the consumer actually takes (head visible while valid & ready before the edge).
  byte unsigned got_q[$];
  always @(negedge clk) begin
    if (!reset && ascii_valid && ascii_ready) got_q.push_back(ascii_out);
  end

  // ---------------- behavioural keyboard model ----------------
  byte unsigned exp_q[$];
  byte unsigned keymap[byte unsigned];
  bit  m_brk, m_ext, m_ls, m_rs, m_caps, m_caps_held, m_kd, m_ovf;
  byte unsigned m_last;
  int  m_occ;

  function automatic void init_map();
    byte unsigned letters[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned digits[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
      8'h3E, 8'h46};
    for (int i = 0; i < 26; i++) keymap[letters[i]] = 8'(8'h61 + i);
    for (int i = 0; i < 10; i++) keymap[digits[i]] = 8'(8'h30 + i);
    keymap[8'h29] = 8'h20;
    keymap[8'h5A] = 8'h0D;
    keymap[8'h66] = 8'h08;
  endfunction

  function automatic void model_reset();
    m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_caps_held = 0;
    m_kd = 0; m_ovf = 0; m_last = 0; m_occ = 0;
    exp_q.delete();
  endfunction

  function automatic void model_make(byte unsigned b, bit ready);
    byte unsigned c;
    if (b == 8'h12) m_ls = 1;
    else if (b == 8'h59) m_rs = 1;
    else if (b == 8'h58) begin
      if (!m_caps_held) m_caps = !m_caps;
      m_caps_held = 1;
    end else begin
      m_last = b;
      m_kd = 1;
      if (keymap.exists(b)) begin
        c = keymap[b];
        if (c >= 8'h61 && c <= 8'h7A && ((m_ls || m_rs) != m_caps)) c = c - 8'h20;
        if (m_occ < DEPTH) begin
          exp_q.push_back(c);
          if (!ready) m_occ++;
        end else m_ovf = 1;
      end
    end
  endfunction

  function automatic void model_break(byte unsigned b);
    if (b == 8'h12) m_ls = 0;
    else if (b == 8'h59) m_rs = 0;
    else if (b == 8'h58) m_caps_held = 0;
    else if (b == m_last) m_kd = 0;
  endfunction

  function automatic void model_byte(byte unsigned b, bit ready);
    if (m_ext) begin
      if (m_brk) begin m_ext = 0; m_brk = 0; end
      else if (b == 8'hF0) m_brk = 1;
      else m_ext = 0;
    end else if (m_brk) begin
      model_break(b);
      m_brk = 0;
    end else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else model_make(b, ready);
  endfunction

  function automatic bit queues_match();
    if (got_q.size() != exp_q.size()) return 0;
    foreach (exp_q[i]) if (got_q[i] != exp_q[i]) return 0;
    return 1;
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_byte(input byte unsigned b, input int gap = 1);
    model_byte(b, ascii_ready);
    key_data  = b;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    got_q.delete();
  endtask

  task automatic drain(input int cycles = 12);
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic compare_chars(input string name);
    n_total++;
    if (!queues_match()) $display("FAIL %s: got %p required %p", name, got_q, exp_q);
    else n_pass++;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_state(input string name);
    n_total++;
    if ({key_down, last_code, caps_on, overflow} !== {m_kd, m_last, m_caps, m_ovf})
      $display("FAIL %s: kd=%0b last=%h caps=%0b ovf=%0b required kd=%0b last=%h caps=%0b ovf=%0b",
               name, key_down, last_code, caps_on, overflow, m_kd, m_last, m_caps, m_ovf);
    else n_pass++;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++;
    if ({ascii_out, ascii_valid, key_down, last_code, caps_on, overflow} !== 20'h0)
      $display("FAIL reset_outputs: out=%h valid=%0b kd=%0b last=%h caps=%0b ovf=%0b required all 0",
               ascii_out, ascii_valid, key_down, last_code, caps_on, overflow);
    else n_pass++;
  endtask

  task automatic test_make_break();
    apply_reset();
    ascii_ready = 1'b1;
    send_byte(8'h1C);
    n_total++;
    if (key_down !== 1'b1) $display("FAIL make_key_down: got %0b required 1", key_down);
    else n_pass++;
    send_byte(8'hF0);
    send_byte(8'h1C);
    n_total++;
    if (key_down !== 1'b0) $display("FAIL break_key_down: got %0b required 0", key_down);
    else n_pass++;
    drain();
    n_total++;
    if (!(exp_q.size() == 1 && exp_q[0] == 8'h61))
      $display("FAIL make_break_model: model expects %p required one 0x61", exp_q);
    else n_pass++;
    compare_chars("make_break_chars");
    compare_state("make_break_state");
  endtask

  task automatic test_shift();
    byte unsigned seq[7] = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    apply_reset();
    foreach (seq[i]) send_byte(seq[i]);
    drain();
    compare_chars("shift_chars");
    compare_state("shift_state");
  endtask

  task automatic test_caps();
    apply_reset();
    send_byte(8'h58);
    n_total++;
    if (caps_on !== 1'b1) $display("FAIL caps_first_press: got %0b required 1", caps_on);
    else n_pass++;
    send_byte(8'h58);
    send_byte(8'h58);
    send_byte(8'hF0);
    send_byte(8'h58);
    n_total++;
    if (caps_on !== 1'b1) $display("FAIL caps_typematic: got %0b required 1", caps_on);
    else n_pass++;
    send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'h58);
    send_byte(8'hF0); send_byte(8'h58);
    n_total++;
    if (caps_on !== 1'b0) $display("FAIL caps_second_press: got %0b required 0", caps_on);
    else n_pass++;
    drain();
    compare_chars("caps_chars");
    compare_state("caps_state");
  endtask

  task automatic test_extended();
    byte unsigned seq[8] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h16, 8'hE0, 8'h12};
    apply_reset();
    foreach (seq[i]) send_byte(seq[i]);
    send_byte(8'h1C);
    drain();
    compare_chars("extended_chars");
    compare_state("extended_state");
  endtask

  task automatic test_overflow();
    apply_reset();
    ascii_ready = 1'b0;
    repeat (DEPTH + 1) send_byte(8'h1C);
    n_total++;
    if (ascii_valid !== 1'b1) $display("FAIL overflow_valid: got %0b required 1", ascii_valid);
    else n_pass++;
    compare_state("overflow_state");
    // Simultaneous push and pop while full must keep the character and leave count unchanged.
    ascii_ready = 1'b1;
    m_occ = 0;
    send_byte(8'h32, 0);
    ascii_ready = 1'b0;
    m_occ = DEPTH;
    drain(2);
    ascii_ready = 1'b1;
    m_occ = 0;
    drain(DEPTH + 4);
    n_total++;
    if (ascii_valid !== 1'b0) $display("FAIL overflow_drained_valid: got %0b required 0", ascii_valid);
    else n_pass++;
    compare_chars("overflow_chars");
  endtask

  task automatic test_reset_mid();
    apply_reset();
    send_byte(8'hF0);
    apply_reset();
    n_total++;
    if ({ascii_valid, key_down, last_code, caps_on, overflow} !== 12'h0)
      $display("FAIL mid_reset_outputs: valid=%0b kd=%0b last=%h caps=%0b ovf=%0b required all 0",
               ascii_valid, key_down, last_code, caps_on, overflow);
    else n_pass++;
    send_byte(8'h1C);
    drain();
    compare_chars("mid_reset_chars");
  endtask

  task automatic test_random();
    byte unsigned pool[16] = '{8'hF0, 8'hF0, 8'hE0, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h32,
      8'h1A, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h75};
    apply_reset();
    ascii_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send_byte(pool[$urandom_range(15)], int'($urandom_range(1)));
      if (i % 50 == 49) begin
        drain(4);
        compare_chars("random_chars");
        compare_state("random_state");
      end
    end
  endtask

  initial begin
    init_map();
    model_reset();
    test_reset();
    test_make_break();
    test_shift();
    test_caps();
    test_extended();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
